// File: rtl/blc_pkg.sv
// Shared constants and state encoding for the black-level statistics stages.
// Default geometry: 128 sorted 8-bit samples, 32 trimmed from each end.
package blc_pkg;

  localparam int BLC_DATA_WIDTH = 8;
  localparam int BLC_N          = 128;
  localparam int BLC_TRIM       = 32;

  // Kept window size and derived widths for the default geometry.
  localparam int BLC_KEEP      = BLC_N - 2 * BLC_TRIM;
  localparam int BLC_KEEP_LOG2 = $clog2(BLC_KEEP);
  localparam int BLC_ACC_W     = BLC_DATA_WIDTH + BLC_KEEP_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sorted_trim_mean.sv
// Trimmed-mean and median estimator over one sorted sample vector.
// Captures the kept window (lanes TRIM..N-TRIM-1) plus the median lane, adds the
// kept lanes one per cycle, then divides by KEEP with a shift.
// Build option: define TRIM_MEAN_ROUND_EN for round-half-up with saturation;
// otherwise the mean is truncated.
module sorted_trim_mean
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH = blc_pkg::BLC_DATA_WIDTH,
  parameter int N          = blc_pkg::BLC_N,
  parameter int TRIM       = blc_pkg::BLC_TRIM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] idata,
  input  logic                    ivalid,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   mean,
  output logic [DATA_WIDTH-1:0]   median,
  output logic                    ovalid
);

  localparam int KEEP      = N - 2 * TRIM;
  localparam int KEEP_LOG2 = $clog2(KEEP);
  localparam int ACC_W     = DATA_WIDTH + KEEP_LOG2;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    capture;
  logic                    accumulate;
  logic                    finish;
  logic                    last_add;

  logic [KEEP_LOG2-1:0]    cnt_reg;
  logic [ACC_W-1:0]        acc_reg;
  logic [DATA_WIDTH-1:0]   med_hold_reg;
  logic [DATA_WIDTH-1:0]   mean_reg;
  logic [DATA_WIDTH-1:0]   median_reg;
  logic                    busy_reg;
  logic                    ovalid_reg;

  logic [DATA_WIDTH-1:0]   kept_lane [KEEP];
  logic [DATA_WIDTH-1:0]   buf_reg   [KEEP];
  logic [DATA_WIDTH-1:0]   median_lane;
  logic [DATA_WIDTH-1:0]   mean_calc;

  // Only the kept window and the median lane are ever needed from the input.
  generate
    for (genvar gi = 0; gi < KEEP; gi++) begin : g_kept
      assign kept_lane[gi] = DATA_WIDTH'(idata >> ((TRIM + gi) * DATA_WIDTH));
    end
  endgenerate

  assign median_lane = DATA_WIDTH'(idata >> ((N / 2) * DATA_WIDTH));
  assign last_add    = (cnt_reg == KEEP_LOG2'(KEEP - 1));

  // Divide the final sum by KEEP.
`ifdef TRIM_MEAN_ROUND_EN
  logic [ACC_W:0]        acc_rnd;
  logic [DATA_WIDTH:0]   mean_rnd;
  assign acc_rnd   = {1'b0, acc_reg} + (ACC_W + 1)'(KEEP / 2);
  assign mean_rnd  = (DATA_WIDTH + 1)'(acc_rnd >> KEEP_LOG2);
  assign mean_calc = mean_rnd[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : mean_rnd[DATA_WIDTH-1:0];
`else
  assign mean_calc = DATA_WIDTH'(acc_reg >> KEEP_LOG2);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and datapath strobes; ivalid is only honoured in IDLE.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    accumulate = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ivalid) begin
          capture    = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        accumulate = 1'b1;
        if (last_add) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample buffer holding the kept window; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < KEEP; i++) begin
        buf_reg[i] <= kept_lane[i];
      end
    end
  end

  // Accumulator, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      med_hold_reg <= '0;
      mean_reg     <= '0;
      median_reg   <= '0;
      busy_reg     <= 1'b0;
      ovalid_reg   <= 1'b0;
    end else begin
      ovalid_reg <= 1'b0;
      if (capture) begin
        med_hold_reg <= median_lane;
        acc_reg      <= '0;
        cnt_reg      <= '0;
        busy_reg     <= 1'b1;
      end
      if (accumulate) begin
        acc_reg <= acc_reg + ACC_W'(buf_reg[cnt_reg]);
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (finish) begin
        mean_reg   <= mean_calc;
        median_reg <= med_hold_reg;
        ovalid_reg <= 1'b1;
        busy_reg   <= 1'b0;
      end
    end
  end

  assign busy   = busy_reg;
  assign mean   = mean_reg;
  assign median = median_reg;
  assign ovalid = ovalid_reg;

endmodule
